entropy_conditioner: RTL and testbench

- Sits directly downstream of the entropy synchronizer and consumes its registered raw bit stream.
- Removes bias with a von Neumann extractor: non-overlapping bit pairs, 01->0, 10->1, 00/11 discarded.
- Packs extracted bits into WORD_W-bit words and presents them on a valid/ready interface to the TRNG output FIFO/bus stage.
- Raw entropy cannot be stalled, so words that complete while the output is blocked are dropped and flagged.

---
 rtl/entropy_conditioner_pkg.sv | 6 +
 rtl/entropy_conditioner_vn_extractor.sv | 31 +++
 rtl/entropy_conditioner.sv | 116 +++++++++++
 tb/tb_entropy_conditioner.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/entropy_conditioner_pkg.sv
// trng_pkg: shared defaults and the pair-state type for the entropy conditioner.
package trng_pkg;
    localparam int TRNG_WORD_W_DEF    = 8;
    localparam int TRNG_REP_LIMIT_DEF = 32;
    typedef enum logic {PAIR_EMPTY, PAIR_HAVE_FIRST} pair_state_t;
endpackage

// File: rtl/entropy_conditioner_vn_extractor.sv
// vn_extractor: von Neumann debiaser over non-overlapping raw bit pairs (01->0, 10->1).
module vn_extractor
    import trng_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic bit_in,
    output logic ext_valid,
    output logic ext_bit
);
    pair_state_t state_q, state_d;
    logic        first_q, first_d;

    always_comb begin
        state_d   = !enable ? PAIR_EMPTY : (state_q == PAIR_EMPTY ? PAIR_HAVE_FIRST : PAIR_EMPTY);
        first_d   = (enable && state_q == PAIR_EMPTY) ? bit_in : first_q;
        ext_valid = enable && state_q == PAIR_HAVE_FIRST && bit_in != first_q;
        ext_bit   = first_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= PAIR_EMPTY;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            first_q <= first_d;
        end
    end
endmodule

// File: rtl/entropy_conditioner.sv
// entropy_conditioner: debias, pack LSB-first into words, drop-and-flag on backpressure.
// Optional repetition-count health test enabled by defining TRNG_HEALTH_TEST_EN.
module entropy_conditioner
    import trng_pkg::*;
#(
    parameter int WORD_W    = TRNG_WORD_W_DEF,
    parameter int REP_LIMIT = TRNG_REP_LIMIT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              bit_in,
    output logic [WORD_W-1:0] word_data,
    output logic              word_valid,
    input  logic              word_ready,
    output logic              overrun,
    output logic              health_fail
);
    localparam int CW = (WORD_W > 2) ? $clog2(WORD_W) : 1;

    if (WORD_W < 2 || WORD_W > 32) begin : g_bad_word_w
        $error("entropy_conditioner: WORD_W out of range 2..32");
    end
    if (REP_LIMIT < 2 || REP_LIMIT > 255) begin : g_bad_rep_limit
        $error("entropy_conditioner: REP_LIMIT out of range 2..255");
    end

    logic              ext_valid, ext_bit;
    logic [WORD_W-1:0] shift_q, shift_d, data_q, data_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              valid_q, valid_d, overrun_q, overrun_d;
    logic              complete, load, hit, hf;

    vn_extractor u_vn (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .bit_in    (bit_in),
        .ext_valid (ext_valid),
        .ext_bit   (ext_bit)
    );

`ifdef TRNG_HEALTH_TEST_EN
    logic [7:0] run_q, run_d;
    logic       last_q, last_d, hf_q, hf_d;

    // run_q starts at 0, so the first bit after reset naturally counts as 1
    always_comb begin
        run_d  = run_q;
        last_d = last_q;
        if (enable) begin
            run_d  = (bit_in == last_q) ? (run_q == 8'hFF ? run_q : run_q + 8'd1) : 8'd1;
            last_d = bit_in;
        end
        hit  = enable && run_d == 8'(REP_LIMIT);
        hf_d = hf_q || hit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q  <= '0;
            last_q <= 1'b0;
            hf_q   <= 1'b0;
        end else begin
            run_q  <= run_d;
            last_q <= last_d;
            hf_q   <= hf_d;
        end
    end

    assign hf = hf_q;
`else
    assign hit = 1'b0;
    assign hf  = 1'b0;
`endif

    always_comb begin
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        complete = ext_valid && cnt_q == CW'(WORD_W - 1);
        if (ext_valid) begin
            shift_d[cnt_q] = ext_bit;
            cnt_d          = complete ? '0 : cnt_q + 1'b1;
        end
        if (hit) begin
            shift_d = '0;
            cnt_d   = '0;
        end
        // a word completing on the accepting edge replaces the old one without loss
        load      = complete && !hit && !hf && (!valid_q || word_ready);
        valid_d   = load || (valid_q && !word_ready);
        data_d    = load ? shift_d : data_q;
        overrun_d = overrun_q || (complete && !hit && !hf && valid_q && !word_ready);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q   <= '0;
            cnt_q     <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign word_data   = data_q;
    assign word_valid  = valid_q;
    assign overrun     = overrun_q;
    assign health_fail = hf;
endmodule

// File: tb/tb_entropy_conditioner.sv
// tb_entropy_conditioner: directed vector table plus hand-written backpressure/enable/reset/health sequences.
module tb_entropy_conditioner;
    logic       clk = 1'b0;
    logic       rst_n, enable, bit_in, word_ready;
    logic [7:0] word_data;
    logic       word_valid, overrun, health_fail;
    int         errors = 0;
    int         checks = 0;
    bit         flag;

    typedef struct {
        logic [31:0] raw;
        int          n;
        logic [7:0]  exp;
    } vec_t;
    vec_t vecs[6];

    entropy_conditioner dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .bit_in      (bit_in),
        .word_data   (word_data),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .overrun     (overrun),
        .health_fail (health_fail)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // raw[0] goes first; with quiet set, word_valid must stay low until the last bit's edge
    task automatic feed(input logic [31:0] raw, input int n, input bit quiet);
        bit early = 1'b0;
        for (int i = 0; i < n; i++) begin
            enable = 1'b1;
            bit_in = raw[i];
            tick();
            if (quiet && i < n - 1 && word_valid) early = 1'b1;
        end
        if (quiet) chk("no_early_valid", {31'd0, early}, 32'd0);
    endtask

    task automatic idle(input int n);
        enable = 1'b0;
        repeat (n) tick();
    endtask

    initial begin
        vecs[0] = '{raw: 32'h0000_6666, n: 16, exp: 8'hAA};
        vecs[1] = '{raw: 32'h0000_9999, n: 16, exp: 8'h55};
        vecs[2] = '{raw: 32'h0000_5555, n: 16, exp: 8'hFF};
        vecs[3] = '{raw: 32'h0000_AAAA, n: 16, exp: 8'h00};
        vecs[4] = '{raw: 32'h0000_AA55, n: 16, exp: 8'h0F};
        vecs[5] = '{raw: 32'h005E_25E1, n: 24, exp: 8'hCD};

        rst_n = 1'b0; enable = 1'b0; bit_in = 1'b0; word_ready = 1'b0;
        repeat (3) tick();
        chk("reset_data", {24'd0, word_data}, 32'd0);
        chk("reset_valid", {31'd0, word_valid}, 32'd0);
        chk("reset_overrun", {31'd0, overrun}, 32'd0);
        chk("reset_health", {31'd0, health_fail}, 32'd0);
        rst_n = 1'b1;
        flag = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (word_valid) flag = 1'b1;
        end
        chk("idle_no_valid", {31'd0, flag}, 32'd0);

        word_ready = 1'b1;
        for (int v = 0; v < 6; v++) begin
            feed(vecs[v].raw, vecs[v].n, 1'b1);
            chk("vec_valid", {31'd0, word_valid}, 32'd1);
            chk("vec_data", {24'd0, word_data}, {24'd0, vecs[v].exp});
            idle(1);
            chk("vec_valid_one_cycle", {31'd0, word_valid}, 32'd0);
        end

        flag = 1'b0;
        for (int i = 0; i < 200; i++) begin
            enable = 1'b1;
            bit_in = (i % 4) >= 2;
            tick();
            if (word_valid) flag = 1'b1;
        end
        chk("discard_no_valid", {31'd0, flag}, 32'd0);
        feed(32'h5555, 16, 1'b1);
        chk("discard_then_ff", {23'd0, word_valid, word_data}, {23'd0, 1'b1, 8'hFF});
        idle(1);

        word_ready = 1'b0;
        feed(32'hAA55, 16, 1'b1);
        chk("simul_first", {23'd0, word_valid, word_data}, {23'd0, 1'b1, 8'h0F});
        feed(32'h9999, 15, 1'b0);
        chk("simul_held", {23'd0, word_valid, word_data}, {23'd0, 1'b1, 8'h0F});
        word_ready = 1'b1;
        feed(32'h9999 >> 15, 1, 1'b0);
        chk("simul_new_word", {23'd0, word_valid, word_data}, {23'd0, 1'b1, 8'h55});
        chk("simul_no_overrun", {31'd0, overrun}, 32'd0);
        idle(1);
        chk("simul_accept", {31'd0, word_valid}, 32'd0);

        word_ready = 1'b0;
        feed(32'h5555, 16, 1'b1);
        chk("bp_first", {23'd0, word_valid, word_data}, {23'd0, 1'b1, 8'hFF});
        chk("bp_no_overrun_yet", {31'd0, overrun}, 32'd0);
        feed(32'hAAAA, 16, 1'b0);
        chk("bp_held", {23'd0, word_valid, word_data}, {23'd0, 1'b1, 8'hFF});
        chk("bp_overrun", {31'd0, overrun}, 32'd1);
        word_ready = 1'b1;
        idle(1);
        chk("bp_accept", {31'd0, word_valid}, 32'd0);
        idle(2);
        chk("bp_single_accept", {31'd0, word_valid}, 32'd0);
        chk("bp_overrun_sticky", {31'd0, overrun}, 32'd1);

        feed(32'hAA55, 8, 1'b1);
        idle(3);
        feed(32'h1, 1, 1'b0);
        idle(2);
        feed(32'hAA55 >> 8, 8, 1'b1);
        chk("enable_align", {23'd0, word_valid, word_data}, {23'd0, 1'b1, 8'h0F});
        idle(1);

        feed(32'h5555, 8, 1'b0);
        enable = 1'b0;
        rst_n = 1'b0;
        #2;
        chk("async_reset", {22'd0, word_valid, overrun, word_data}, 32'd0);
        rst_n = 1'b1;
        tick();
        feed(32'hAAAA, 16, 1'b1);
        chk("post_reset_word", {23'd0, word_valid, word_data}, {23'd0, 1'b1, 8'h00});
        idle(1);

        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
`ifdef TRNG_HEALTH_TEST_EN
        feed(32'hFFFF_FFFF, 31, 1'b0);
        chk("health_before_limit", {31'd0, health_fail}, 32'd0);
        feed(32'h1, 1, 1'b0);
        chk("health_at_limit", {31'd0, health_fail}, 32'd1);
        flag = 1'b0;
        for (int i = 0; i < 16; i++) begin
            enable = 1'b1;
            bit_in = (i % 2) == 0;
            tick();
            if (word_valid) flag = 1'b1;
        end
        chk("health_blocks_words", {31'd0, flag}, 32'd0);
        chk("health_sticky", {31'd0, health_fail}, 32'd1);
`else
        feed(32'hFFFF_FFFF, 32, 1'b0);
        chk("health_tied_low", {31'd0, health_fail}, 32'd0);
        feed(32'h5555, 16, 1'b1);
        chk("no_health_word", {23'd0, word_valid, word_data}, {23'd0, 1'b1, 8'hFF});
`endif
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
